nios_system_nios2_communication_div_cell: RTL and testbench

- Iterative 32-bit integer divider for the Nios II M-stage; the inverse operation of the existing multiply cell.
- Serves div/divu: radix-2 restoring division on magnitudes, then sign fix-up.
- Multi-cycle, with a start/busy/done handshake to the pipeline stall logic.
- Produces quotient and remainder; the remainder feeds software modulo helpers.

---
 rtl/nios_system_nios2_communication_div_pkg.sv | 16 +
 rtl/nios_system_nios2_communication_div_step.sv | 25 ++
 rtl/nios_system_nios2_communication_div_cell.sv | 160 ++++++++++++++++
 tb/tb_nios_system_nios2_communication_div_cell.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_nios2_communication_div_pkg.sv
// Shared types and constants for the Nios II M-stage iterative divider.
// Optional build macro: NIOS_DIV_ZERO_FASTPATH_EN (see top module).
package nios_system_nios2_communication_div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = $clog2(DIV_DATA_W + 1);

  localparam logic [DIV_DATA_W-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } div_state_e;

endpackage

// File: rtl/nios_system_nios2_communication_div_step.sv
// One radix-2 restoring division step: shift, compare, subtract.
// Partial remainder comparison is done at DATA_W+1 bits.
module nios_system_nios2_communication_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted;
  logic            ge;

  assign shifted = {rem_i, quo_i[DATA_W-1]};
  assign ge      = (shifted >= {1'b0, dvs_i});

  // When ge holds the true difference is below 2^DATA_W,
  // so the modulo subtract on the low bits is exact.
  assign rem_o = ge ? (shifted[DATA_W-1:0] - dvs_i)
                    : shifted[DATA_W-1:0];
  assign quo_o = {quo_i[DATA_W-2:0], ge};

endmodule

// File: rtl/nios_system_nios2_communication_div_cell.sv
// Iterative div/divu cell: restoring division on magnitudes plus sign fix-up.
// Define NIOS_DIV_ZERO_FASTPATH_EN to answer divide-by-zero in one cycle.
module nios_system_nios2_communication_div_cell
  import nios_system_nios2_communication_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              M_div_start,
  input  logic              M_div_abort,
  input  logic              M_div_signed,
  input  logic [DATA_W-1:0] M_div_src1,
  input  logic [DATA_W-1:0] M_div_src2,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_cell_result,
  output logic [DATA_W-1:0] M_div_cell_rem
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] Q_DIV0 = DATA_W'(DIV0_QUOTIENT);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  div_state_e state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] prem_q, prem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              div0_q, div0_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] remo_q, remo_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_quo;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic              in_div0;
  logic              s1_neg;
  logic              s2_neg;

  assign s1_neg  = M_div_signed & M_div_src1[DATA_W-1];
  assign s2_neg  = M_div_signed & M_div_src2[DATA_W-1];
  assign abs1    = s1_neg ? -M_div_src1 : M_div_src1;
  assign abs2    = s2_neg ? -M_div_src2 : M_div_src2;
  assign in_div0 = (M_div_src2 == '0);

  nios_system_nios2_communication_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem_i (prem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    div0_d  = div0_q;
    res_d   = res_q;
    remo_d  = remo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (M_div_start && !M_div_abort) begin
          negq_d = s1_neg ^ s2_neg;
          negr_d = s1_neg;
          div0_d = in_div0;
          dvs_d  = abs2;
          // Divisor 0 shifts the raw dividend through as remainder.
          quo_d  = in_div0 ? M_div_src1 : abs1;
          prem_d = '0;
          cnt_d  = '0;
`ifdef NIOS_DIV_ZERO_FASTPATH_EN
          if (in_div0) begin
            res_d  = Q_DIV0;
            remo_d = M_div_src1;
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        if (M_div_abort) begin
          state_d = IDLE;
        end else begin
          prem_d = step_rem;
          quo_d  = step_quo;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!M_div_abort) begin
          done_d = 1'b1;
          if (div0_q) begin
            res_d  = Q_DIV0;
            remo_d = prem_q;
          end else begin
            res_d  = negq_q ? -quo_q : quo_q;
            remo_d = negr_q ? -prem_q : prem_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
      res_q   <= '0;
      remo_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      div0_q  <= div0_d;
      res_q   <= res_d;
      remo_q  <= remo_d;
      done_q  <= done_d;
    end
  end

  assign M_div_busy        = (state_q != IDLE);
  assign M_div_done        = done_q;
  assign M_div_cell_result = res_q;
  assign M_div_cell_rem    = remo_q;

endmodule

// File: tb/tb_nios_system_nios2_communication_div_cell.sv
// Scoreboard bench for the iterative divider cell.
// Honours NIOS_DIV_ZERO_FASTPATH_EN for divide-by-zero latency.
module tb_nios_system_nios2_communication_div_cell;

  localparam int W   = 32;
  localparam int LAT = W + 2;
`ifdef NIOS_DIV_ZERO_FASTPATH_EN
  localparam int LAT0 = 1;
`else
  localparam int LAT0 = LAT;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic         sgn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic [W-1:0] rem;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  nios_system_nios2_communication_div_cell dut (
    .clk               (clk),
    .reset_n           (rst_n),
    .M_div_start       (start),
    .M_div_abort       (abort),
    .M_div_signed      (sgn),
    .M_div_src1        (a),
    .M_div_src2        (b),
    .M_div_busy        (busy),
    .M_div_done        (done),
    .M_div_cell_result (res),
    .M_div_cell_rem    (rem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done cyc=%0d q=%h r=%h",
                 cyc, res, rem);
      end else begin
        e = sb.pop_front();
        checks += 3;
        if (res !== e.q) begin
          errors++;
          $display("FAIL quotient got=%h exp=%h", res, e.q);
        end
        if (rem !== e.r) begin
          errors++;
          $display("FAIL remainder got=%h exp=%h", rem, e.r);
        end
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL done_cycle got=%0d exp=%0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic s, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] eq,
                       input logic [W-1:0] er, input int lat,
                       input bit push);
    sgn   = s;
    a     = x;
    b     = y;
    start = 1'b1;
    if (push) sb.push_back('{q: eq, r: er, cyc: cyc + lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle timeout pending=%0d busy=%b",
             sb.size(), busy);
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    sgn   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done got=%b exp=0", done);
    end
    if (res !== '0) begin
      errors++; $display("FAIL reset_result got=%h exp=0", res);
    end
    if (rem !== '0) begin
      errors++; $display("FAIL reset_rem got=%h exp=0", rem);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_unsigned_timing();
    int s0;
    s0 = cyc;
    drive(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, LAT, 1'b1);
    for (int k = 0; k <= LAT; k++) begin
      int c;
      c = cyc - s0;
      checks += 2;
      if (busy !== (c <= W + 1)) begin
        errors++;
        $display("FAIL busy_c%0d got=%b exp=%b", c, busy, c <= W + 1);
      end
      if (done !== (c == LAT)) begin
        errors++;
        $display("FAIL done_c%0d got=%b exp=%b", c, done, c == LAT);
      end
      if (k < LAT) @(negedge clk);
    end
    wait_idle(10);
  endtask

  task automatic test_signed();
    drive(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
          LAT, 1'b1);
    wait_idle(60);
    drive(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, LAT, 1'b1);
    wait_idle(60);
    drive(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, LAT, 1'b1);
    wait_idle(60);
    drive(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
          LAT, 1'b1);
    wait_idle(60);
    drive(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
          LAT, 1'b1);
    wait_idle(60);
  endtask

  task automatic test_div_zero();
    drive(1'b1, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, LAT0, 1'b1);
    checks++;
    if (busy !== (LAT0 != 1)) begin
      errors++;
      $display("FAIL div0_busy got=%b exp=%b", busy, LAT0 != 1);
    end
    wait_idle(60);
    drive(1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, LAT0, 1'b1);
    wait_idle(60);
    drive(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB,
          LAT0, 1'b1);
    wait_idle(60);
  endtask

  task automatic test_abort();
    logic [W-1:0] pr;
    logic [W-1:0] pm;
    drive(1'b0, 32'd50, 32'd5, '0, '0, 0, 1'b0);
    repeat (9) @(negedge clk);
    pr    = res;
    pm    = rem;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_busy got=%b exp=0", busy);
    end
    if (res !== pr) begin
      errors++; $display("FAIL abort_result got=%h exp=%h", res, pr);
    end
    if (rem !== pm) begin
      errors++; $display("FAIL abort_rem got=%h exp=%h", rem, pm);
    end
    drive(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, LAT, 1'b1);
    wait_idle(60);
    sgn   = 1'b0;
    a     = 32'd20;
    b     = 32'd3;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_abort_busy got=%b exp=0", busy);
    end
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = cyc;
    drive(1'b0, 32'd200, 32'd9, 32'd22, 32'd2, LAT, 1'b1);
    repeat (4) @(negedge clk);
    a     = 32'd1;
    b     = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc - s0 < LAT) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL done_cycle_busy got=%b exp=0", busy);
    end
    drive(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, LAT, 1'b1);
    wait_idle(80);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'hFFFF_FE0C, 32'd7, '0, '0, 0, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy);
    end
    if (done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_done got=%b exp=0", done);
    end
    if (res !== '0) begin
      errors++; $display("FAIL rst_mid_result got=%h exp=0", res);
    end
    if (rem !== '0) begin
      errors++; $display("FAIL rst_mid_rem got=%h exp=0", rem);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idle got=%b exp=0", busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unsigned_timing();
    test_signed();
    test_div_zero();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
